spi_read_sequencer: RTL and testbench
=====================================

// Module: spi_read_sequencer
// PURPOSE
// - Master-side sequencer for spi_interface: drives cs/sck, clocks one 16-bit word, captures data on data_rdy.
// - Sits between the system and spi_interface; spi_interface samples miso on sck rising edges in the sys_clk domain.
// - One transaction per start request; enforces cs setup time and an inter-word cs-high gap.
// PARAMETERS
// - HALF_DIV      default 4    sys_clk cycles per sck half-period (sck freq = sys_clk/(2*HALF_DIV)); legal range >= 2.
// - CS_SETUP      default 2    sys_clk cycles from cs falling to the first sck rising edge; legal range >= 1.
// - GAP_CYCLES    default 4    minimum sys_clk cycles cs is held high after a word; legal range >= 1.
// - NUM_BITS      default 16   sck rising edges per word; must match spi_interface width.
// - TIMEOUT_CYCLES default 64  WAIT_RDY limit; used only with SPI_SEQ_TIMEOUT_EN.
// PORTS
// - sys_clk       in   1   system clock; all logic is posedge.
// - rst_n         in   1   asynchronous active-low reset.
// - start         in   1   level; sampled only in IDLE; 1 starts a transaction.
// - spi_data      in   16  data from spi_interface.
// - spi_data_rdy  in   1   data_rdy from spi_interface.
// - cs            out  1   chip select to spi_interface/device, active low.
// - sck           out  1   serial clock, idle low.
// - sample        out  16  last captured word.
// - sample_valid  out  1   one-cycle pulse when sample updates.
// - busy          out  1   high in every state except IDLE.
// - timeout_err   out  1   one-cycle pulse on timeout (tied 0 without the macro).
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; cs=1, sck=0, sample=0, sample_valid=0, busy=0, timeout_err=0; counters=0.
// - All outputs are registered; no combinational input-to-output path.
// - IDLE: cs=1, sck=0. If start=1: -> SETUP, cs<=0, busy<=1 (visible the next cycle).
// - SETUP: hold sck=0 for CS_SETUP cycles; then -> CLOCK.
// - CLOCK: sck low for HALF_DIV cycles, then high for HALF_DIV cycles, and repeat.
//   - Count the rising edges of sck.
//   - After the NUM_BITS-th high phase, drive sck low and -> WAIT_RDY.
//   - sck never stays high for fewer than 2 sys_clk cycles, so spi_interface sees every edge.
// - WAIT_RDY: cs stays 0, sck=0.
//   - On spi_data_rdy=1: sample<=spi_data, sample_valid<=1 for one cycle, -> GAP.
// - GAP: cs<=1 on entry; hold for GAP_CYCLES cycles; -> IDLE; busy deasserts on return to IDLE.
//   - cs stays low until the capture cycle, because spi_interface clears its data whenever cs is high.
// - Back-to-back transactions: start held at 1 gives a new transaction every CS_SETUP + 2*HALF_DIV*NUM_BITS + (rdy wait) + GAP_CYCLES + 1 cycles.
// - Start handling: start during a non-IDLE state is ignored (no queueing). A start pulse that falls while the block is busy is lost.
// - A spurious spi_data_rdy outside WAIT_RDY is ignored; sample does not change.
// - Reset mid-transaction: asserting rst_n=0 forces the reset values immediately. cs rising also resets spi_interface. No sample_valid is produced.
// - Counter widths use $clog2 of (max parameter + 1); counters never wrap inside a state.
// CONFIGURATION
// - SPI_SEQ_TIMEOUT_EN defined:
//   - WAIT_RDY counts cycles.
//   - If spi_data_rdy is still 0 after TIMEOUT_CYCLES cycles: timeout_err=1 for one cycle, sample is unchanged, no sample_valid, -> GAP.
//   - If data_rdy and timeout occur in the same cycle, data_rdy wins (capture, no error).
// - SPI_SEQ_TIMEOUT_EN undefined: WAIT_RDY waits indefinitely; timeout_err is constant 0; no timeout counter logic.
// TESTING
// - Reset: assert rst_n mid-CLOCK -> cs=1, sck=0, busy=0, sample=0 asynchronously; no sample_valid after release.
// - Single read (defaults): spi_interface model with miso pattern 0xA5C3, start pulse 1 cycle.
//   - Required: exactly 16 sck rising edges, sck high 4 cycles and low 4 cycles.
//   - Required: first rising edge 2+4 cycles after cs falls.
//   - Required: sample=0xA5C3 with one sample_valid pulse while cs is still 0, then cs high for 4 cycles.
// - Back-to-back: start held 1, words 0x0001 then 0xFFFF -> two sample_valid pulses, samples in order, cs-high gap >= 4 cycles between them.
// - Start while busy: pulse start mid-CLOCK -> no extra transaction; exactly 16 edges; one sample_valid.
// - Spurious rdy: force spi_data_rdy=1 during SETUP -> sample unchanged; transaction completes normally.
// - Timeout (macro on, TIMEOUT_CYCLES=64): hold spi_data_rdy=0 -> timeout_err pulse 64 cycles after WAIT_RDY entry; sample unchanged; cs rises; busy drops after the gap.

Source files
------------

// File: rtl/spi_read_sequencer_if.sv
// spi_read_sequencer_if: request/result handshake plus the cs/sck/data/data_rdy link to spi_interface.
interface spi_read_sequencer_if #(parameter int W = 16);
    logic         start;
    logic [W-1:0] spi_data;
    logic         spi_data_rdy;
    logic         cs;
    logic         sck;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic         busy;
    logic         timeout_err;
    modport master (
        input  start, spi_data, spi_data_rdy,
        output cs, sck, sample, sample_valid, busy, timeout_err
    );
    modport slave (
        output start, spi_data, spi_data_rdy,
        input  cs, sck, sample, sample_valid, busy, timeout_err
    );
endinterface

// File: rtl/spi_read_sequencer.sv
// spi_read_sequencer: drives cs/sck for one NUM_BITS read per start and captures the word on data_rdy.
// Define SPI_SEQ_TIMEOUT_EN to abort WAIT_RDY after TIMEOUT_CYCLES with a timeout_err pulse.
module spi_read_sequencer #(
    parameter int HALF_DIV       = 4,
    parameter int CS_SETUP       = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int NUM_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  sys_clk,
    input logic                  rst_n,
    spi_read_sequencer_if.master bus
);
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int MAX_T = TIMEOUT_CYCLES;
`else
    localparam int MAX_T = 1;
`endif
    localparam int MAX_A = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
    localparam int MAX_B = (GAP_CYCLES > MAX_T) ? GAP_CYCLES : MAX_T;
    localparam int CW    = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);
    localparam int BW    = $clog2(NUM_BITS + 1);
    typedef enum logic [2:0] {IDLE, SETUP, CLOCK, WAIT_RDY, GAP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bits_q, bits_d;
    logic [15:0]   sample_q, sample_d;
    logic          cs_q, cs_d, sck_q, sck_d, valid_q, valid_d, busy_q, busy_d, terr_q, terr_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bits_d   = bits_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        terr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                if (bus.start) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                end
            end
            SETUP: if (cnt_q == CW'(CS_SETUP - 1)) begin
                state_d = CLOCK;
                cnt_d   = '0;
            end
            // each phase lasts HALF_DIV cycles; a falling edge after the last rise ends the word
            CLOCK: if (cnt_q == CW'(HALF_DIV - 1)) begin
                cnt_d  = '0;
                sck_d  = !sck_q;
                bits_d = sck_q ? bits_q : bits_q + 1'b1;
                if (sck_q && bits_q == BW'(NUM_BITS)) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                cnt_d = '0;
                if (bus.spi_data_rdy) begin
                    sample_d = bus.spi_data;
                    valid_d  = 1'b1;
                    state_d  = GAP;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    state_d = GAP;
                end else cnt_d = cnt_q + 1'b1;
`endif
            end
            // cs rises one cycle after capture so spi_interface keeps its data until then
            GAP: begin
                cs_d = 1'b1;
                if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bits_q   <= '0;
            sample_q <= '0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            sample_q <= sample_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
        end
    end
    assign bus.cs           = cs_q;
    assign bus.sck          = sck_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_spi_read_sequencer.sv
// tb_spi_read_sequencer: directed reads against a small spi_interface model; timing measured on negedges.
module tb_spi_read_sequencer;
    logic sys_clk = 1'b0;
    logic rst_n;
    logic force_rdy, hold_low;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, edges, nvalid, ncsfall, n_terr;
    int   hi_min, hi_max, lo_min, lo_max, gap_min, first_rise;
    int   cs_fall_cyc, last_cs_rise, cs_rise_cyc, last_rise, last_fall, valid_cyc, busy_fall_cyc, terr_cyc;
    logic valid_cs;
    logic [15:0] samp [4];
    logic [15:0] words [4];
    int   wptr;
    logic p_cs = 1'b1, p_sck = 1'b0, p_busy = 1'b0, m_p_cs = 1'b1, m_p_sck = 1'b0;
    logic [15:0] m_sh = '0, m_cur = '0;
    int   m_bits = 0;
    logic m_rdy = 1'b0;
    spi_read_sequencer_if bus ();
    spi_read_sequencer dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));
    always #5 sys_clk = ~sys_clk;
    assign bus.spi_data     = m_sh;
    assign bus.spi_data_rdy = (m_rdy && !hold_low) || force_rdy;
    always @(negedge sys_clk) begin
        cyc++;
        if (!bus.cs && p_cs) begin
            cs_fall_cyc = cyc;
            ncsfall++;
            last_fall = -1;
            if (last_cs_rise >= 0 && cyc - last_cs_rise < gap_min) gap_min = cyc - last_cs_rise;
        end
        if (bus.cs && !p_cs) begin
            last_cs_rise = cyc;
            cs_rise_cyc  = cyc;
        end
        if (bus.sck && !p_sck) begin
            if (first_rise < 0) first_rise = cyc - cs_fall_cyc;
            if (last_fall >= 0) begin
                if (cyc - last_fall < lo_min) lo_min = cyc - last_fall;
                if (cyc - last_fall > lo_max) lo_max = cyc - last_fall;
            end
            last_rise = cyc;
            edges++;
        end
        if (!bus.sck && p_sck) begin
            if (cyc - last_rise < hi_min) hi_min = cyc - last_rise;
            if (cyc - last_rise > hi_max) hi_max = cyc - last_rise;
            last_fall = cyc;
        end
        if (bus.sample_valid) begin
            if (nvalid < 4) samp[nvalid] = bus.sample;
            valid_cyc = cyc;
            valid_cs  = bus.cs;
            nvalid++;
        end
        if (bus.timeout_err) begin
            n_terr++;
            terr_cyc = cyc;
        end
        if (!bus.busy && p_busy) busy_fall_cyc = cyc;
        p_cs   = bus.cs;
        p_sck  = bus.sck;
        p_busy = bus.busy;
        // spi_interface model: MSB-first shift on sck rise, data_rdy after 16 bits, cleared while cs high
        if (bus.cs) begin
            m_sh   = '0;
            m_bits = 0;
            m_rdy  = 1'b0;
        end else begin
            if (m_p_cs && wptr < 4) begin
                m_cur = words[wptr];
                wptr++;
            end
            if (bus.sck && !m_p_sck && m_bits < 16) begin
                m_sh = {m_sh[14:0], m_cur[15-m_bits]};
                m_bits++;
                if (m_bits == 16) m_rdy = 1'b1;
            end
        end
        m_p_cs  = bus.cs;
        m_p_sck = bus.sck;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        edges = 0; nvalid = 0; ncsfall = 0; n_terr = 0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0; gap_min = 999;
        first_rise = -1; last_cs_rise = -1; last_fall = -1; last_rise = 0;
        cs_rise_cyc = 0; valid_cyc = 0; busy_fall_cyc = 0; terr_cyc = 0; cs_fall_cyc = 0;
        valid_cs = 1'b1; wptr = 0;
    endtask
    task automatic pulse_start();
        @(posedge sys_clk); #1 bus.start = 1'b1;
        @(posedge sys_clk); #1 bus.start = 1'b0;
    endtask
    task automatic wait_valid(input int n);
        for (int i = 0; i < 2000 && nvalid < n; i++) @(posedge sys_clk);
        #1;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 2000 && bus.busy; i++) @(posedge sys_clk);
        #1;
    endtask
    task automatic wait_edges(input int n);
        for (int i = 0; i < 2000 && edges < n; i++) @(posedge sys_clk);
        #1;
    endtask
    initial begin
        bus.start = 1'b0; rst_n = 1'b0; force_rdy = 1'b0; hold_low = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = '0;
        clr();
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cs", bus.cs, 1);
        check("rst_sck", bus.sck, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sample", bus.sample, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_terr", bus.timeout_err, 0);
        @(posedge sys_clk); #2 rst_n = 1'b1;
        clr(); words[0] = 16'hA5C3;
        pulse_start();
        check("single_busy_up", bus.busy, 1);
        wait_valid(1);
        wait_idle();
        repeat (5) @(posedge sys_clk);
        #1;
        check("single_valid_cnt", nvalid, 1);
        check("single_edges", edges, 16);
        check("single_hi_min", hi_min, 4);
        check("single_hi_max", hi_max, 4);
        check("single_lo_min", lo_min, 4);
        check("single_lo_max", lo_max, 4);
        check("single_first_rise", first_rise, 6);
        check("single_sample", samp[0], 16'hA5C3);
        check("single_valid_cs_low", valid_cs, 0);
        check("single_cs_rise_after_valid", cs_rise_cyc - valid_cyc, 1);
        check("single_busy_drop_after_valid", busy_fall_cyc - valid_cyc, 4);
        check("single_busy", bus.busy, 0);
        check("single_terr", n_terr, 0);
        clr(); words[0] = 16'h0001; words[1] = 16'hFFFF;
        @(posedge sys_clk); #1 bus.start = 1'b1;
        for (int i = 0; i < 2000 && ncsfall < 2; i++) @(posedge sys_clk);
        #1 bus.start = 1'b0;
        wait_valid(2);
        wait_idle();
        repeat (5) @(posedge sys_clk);
        #1;
        check("b2b_valid_cnt", nvalid, 2);
        check("b2b_sample0", samp[0], 16'h0001);
        check("b2b_sample1", samp[1], 16'hFFFF);
        check("b2b_cs_falls", ncsfall, 2);
        check("b2b_gap", gap_min, 4);
        check("b2b_edges", edges, 32);
        clr(); words[0] = 16'h1234;
        pulse_start();
        wait_edges(5);
        pulse_start();
        wait_valid(1);
        wait_idle();
        repeat (20) @(posedge sys_clk);
        #1;
        check("busy_start_edges", edges, 16);
        check("busy_start_valid_cnt", nvalid, 1);
        check("busy_start_cs_falls", ncsfall, 1);
        check("busy_start_sample", samp[0], 16'h1234);
        clr(); words[0] = 16'h3C96;
        @(posedge sys_clk); #1 bus.start = 1'b1;
        @(posedge sys_clk); #1 bus.start = 1'b0; force_rdy = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1 force_rdy = 1'b0;
        check("spur_sample_held", bus.sample, 16'h1234);
        check("spur_no_valid", nvalid, 0);
        check("spur_busy", bus.busy, 1);
        wait_valid(1);
        wait_idle();
        repeat (5) @(posedge sys_clk);
        #1;
        check("spur_valid_cnt", nvalid, 1);
        check("spur_sample", samp[0], 16'h3C96);
        check("spur_edges", edges, 16);
`ifdef SPI_SEQ_TIMEOUT_EN
        clr(); words[0] = 16'hBEEF; hold_low = 1'b1;
        pulse_start();
        for (int i = 0; i < 2000 && n_terr < 1; i++) @(posedge sys_clk);
        wait_idle();
        repeat (3) @(posedge sys_clk);
        #1;
        check("to_pulses", n_terr, 1);
        check("to_latency", terr_cyc - last_fall, 64);
        check("to_no_valid", nvalid, 0);
        check("to_sample_held", bus.sample, 16'h3C96);
        check("to_cs_rise", cs_rise_cyc - terr_cyc, 1);
        check("to_busy_drop", busy_fall_cyc - terr_cyc, 4);
        hold_low = 1'b0;
`endif
        clr(); words[0] = 16'h0F0F;
        pulse_start();
        wait_edges(3);
        @(posedge sys_clk); #3 rst_n = 1'b0;
        #1;
        check("midrst_cs", bus.cs, 1);
        check("midrst_sck", bus.sck, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_sample", bus.sample, 0);
        @(posedge sys_clk); #2 rst_n = 1'b1;
        clr();
        repeat (40) @(posedge sys_clk);
        #1;
        check("midrst_no_valid", nvalid, 0);
        check("midrst_cs_idle", bus.cs, 1);
        check("midrst_busy_idle", bus.busy, 0);
        check("midrst_no_restart", ncsfall, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
